// File: rtl/pic_isa_pkg.sv
// pic_isa_pkg: PIC16C5x mnemonic codes, opcode base words and encoder state type.
package pic_isa_pkg;
  typedef enum logic [5:0] {
    M_ADDWF, M_ANDWF, M_CLRF, M_CLRW, M_COMF, M_DECF, M_DECFSZ, M_INCF, M_INCFSZ,
    M_IORWF, M_MOVF, M_MOVWF, M_NOP, M_RLF, M_RRF, M_SUBWF, M_SWAPF, M_XORWF,
    M_BCF, M_BSF, M_BTFSC, M_BTFSS,
    M_ANDLW, M_CALL, M_CLRWDT, M_GOTO, M_IORLW, M_MOVLW, M_OPTION, M_RETLW,
    M_SLEEP, M_TRIS, M_XORLW
  } mnem_t;
  localparam logic [5:0] MNEM_COUNT = 6'd33;
  // Opcode bits with every operand field zero, indexed by mnem_t.
  localparam logic [11:0] OP_BASE [0:32] = '{
    12'h1C0, 12'h140, 12'h060, 12'h040, 12'h240, 12'h0C0, 12'h2C0, 12'h280, 12'h3C0,
    12'h100, 12'h200, 12'h020, 12'h000, 12'h340, 12'h300, 12'h080, 12'h380, 12'h180,
    12'h400, 12'h500, 12'h600, 12'h700,
    12'hE00, 12'h900, 12'h004, 12'hA00, 12'hD00, 12'hC00, 12'h002, 12'h800,
    12'h003, 12'h000, 12'hF00
  };
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FULL} enc_state_t;
endpackage

// File: rtl/ins_encode_core.sv
// ins_encode_core: combinational mnemonic + operands -> 12-bit PIC16C5x word and illegal flag.
module ins_encode_core
  import pic_isa_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  f,
  input  logic        d,
  input  logic [2:0]  b,
  input  logic [8:0]  k,
  output logic [11:0] word,
  output logic        illegal
);
  logic [11:0] base;
  assign base = (mnem < MNEM_COUNT) ? OP_BASE[mnem] : 12'h000;
  always_comb begin
    word = base;
    illegal = 1'b0;
    case (mnem)
      M_ADDWF, M_ANDWF, M_COMF, M_DECF, M_DECFSZ, M_INCF, M_INCFSZ, M_IORWF,
      M_MOVF, M_RLF, M_RRF, M_SUBWF, M_SWAPF, M_XORWF: word = base | {6'b0, d, f};
      M_CLRF, M_MOVWF: word = base | {7'b0, f};
      M_BCF, M_BSF, M_BTFSC, M_BTFSS: word = base | {4'b0, b, f};
      M_ANDLW, M_CALL, M_IORLW, M_MOVLW, M_RETLW, M_XORLW: begin
        word = base | {4'b0, k[7:0]};
        illegal = k[8];
      end
      M_GOTO: word = base | {3'b0, k};
      M_TRIS: begin
        word = {9'b0, f[2:0]};
        illegal = (f < 5'd5) || (f > 5'd7);
      end
      M_NOP, M_CLRW, M_OPTION, M_SLEEP, M_CLRWDT: word = base;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ins_encode.sv
// ins_encode: streams encoded instructions into program memory; checksum output when
// INS_ENCODE_CHECKSUM_EN is defined.
module ins_encode
  import pic_isa_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter bit ERR_DROP = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] org_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_f,
  input  logic              in_d,
  input  logic [2:0]        in_bit,
  input  logic [8:0]        in_k,
  output logic              pm_we,
  input  logic              pm_ready,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [11:0]       pm_wdata,
`ifdef INS_ENCODE_CHECKSUM_EN
  output logic [11:0]       checksum,
`endif
  output logic              busy,
  output logic              full,
  output logic              err
);
  enc_state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic top_q, accept, done, keep, illegal;
  logic [11:0] word;
  ins_encode_core u_core (
    .mnem(in_mnem), .f(in_f), .d(in_d), .b(in_bit), .k(in_k), .word(word), .illegal(illegal)
  );
  // top_q blocks beats once the last address holds a word, so the counter never wraps.
  assign in_ready = (state == S_LOAD) && !top_q && (!pm_we || pm_ready);
  assign accept = in_valid && in_ready;
  assign done = pm_we && pm_ready;
  assign keep = !illegal || !ERR_DROP;
  assign busy = state != S_IDLE;
  assign full = state == S_FULL;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_n = finish ? S_DRAIN : (done && pm_addr == '1) ? S_FULL : S_LOAD;
      S_DRAIN: state_n = pm_we ? S_DRAIN : S_IDLE;
      S_FULL:  state_n = finish ? S_DRAIN : S_FULL;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      top_q <= 1'b0;
      pm_we <= 1'b0;
      pm_addr <= '0;
      pm_wdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= accept && illegal;
      if (state == S_IDLE && start) begin
        cnt <= org_addr;
        top_q <= 1'b0;
      end
      if (accept && keep) begin
        pm_we <= 1'b1;
        pm_addr <= cnt;
        pm_wdata <= illegal ? 12'h000 : word;
        if (cnt == '1) top_q <= 1'b1;
        else cnt <= cnt + ADDR_W'(1);
      end else if (done) begin
        pm_we <= 1'b0;
      end
    end
  end
`ifdef INS_ENCODE_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (done) checksum <= checksum + pm_wdata;
  end
`endif
endmodule

// File: tb/tb_ins_encode.sv
// tb_ins_encode: directed and randomized checks of ins_encode against an arithmetic ISA model.
module tb_ins_encode;
  import pic_isa_pkg::*;
  localparam int AW = 9;
  localparam int BYTE_OP6 [18] = '{7, 5, 1, 1, 9, 3, 11, 10, 15, 4, 8, 0, 0, 13, 12, 2, 14, 6};
  logic clock = 0, reset = 1, start = 0, finish = 0, in_valid = 0, in_d = 0, pm_ready = 1;
  logic [AW-1:0] org_addr = '0;
  logic [5:0] in_mnem = '0;
  logic [4:0] in_f = '0;
  logic [2:0] in_bit = '0;
  logic [8:0] in_k = '0;
  logic in_ready, pm_we, busy, full, err;
  logic [AW-1:0] pm_addr;
  logic [11:0] pm_wdata;
`ifdef INS_ENCODE_CHECKSUM_EN
  logic [11:0] checksum;
`endif
  int compared = 0, mismatched = 0;

  always #5 clock = ~clock;

  ins_encode #(.ADDR_W(AW), .ERR_DROP(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .org_addr(org_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_f(in_f), .in_d(in_d),
    .in_bit(in_bit), .in_k(in_k), .pm_we(pm_we), .pm_ready(pm_ready), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata),
`ifdef INS_ENCODE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy), .full(full), .err(err)
  );

  // Encoding straight from the instruction-set tables: opcode field times field weight plus operands.
  function automatic void model(input int m, input int f, input int d, input int b, input int k,
                                output int w, output bit ill);
    int op4;
    w = 0;
    ill = 0;
    if (m >= 33) ill = 1;
    else if (m == 2 || m == 11) w = BYTE_OP6[m] * 64 + 32 + f;
    else if (m == 3 || m == 12) w = BYTE_OP6[m] * 64;
    else if (m < 18) w = BYTE_OP6[m] * 64 + d * 32 + f;
    else if (m < 22) w = (m - 14) * 256 + b * 32 + f;
    else if (m == 25) w = 5 * 512 + k;
    else if (m == 28) w = 2;
    else if (m == 30) w = 3;
    else if (m == 24) w = 4;
    else if (m == 31) begin
      w = f % 8;
      ill = (f < 5) || (f > 7);
    end else begin
      op4 = (m == 22) ? 14 : (m == 23) ? 9 : (m == 26) ? 13 : (m == 27) ? 12 : (m == 29) ? 8 : 15;
      w = op4 * 256 + k % 256;
      ill = k >= 256;
    end
    if (ill) w = 0;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int m, input int f, input int d, input int b, input int k);
    in_valid = 1;
    in_mnem = 6'(m);
    in_f = 5'(f);
    in_d = 1'(d);
    in_bit = 3'(b);
    in_k = 9'(k);
    #1;
    for (int n = 0; !in_ready; n++) begin
      if (n == 50) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout in_ready=0 required=1");
        break;
      end
      @(posedge clock);
      #2;
    end
    @(posedge clock);
    #1;
    in_valid = 0;
  endtask

  task automatic begin_load(input int org);
    org_addr = AW'(org);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic end_load;
    finish = 1;
    tick();
    finish = 0;
    for (int n = 0; busy && n < 50; n++) tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    compared++;
    if ({pm_we, in_ready, busy, full, err, pm_addr, pm_wdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%h/%h required all zero",
               pm_we, in_ready, busy, full, err, pm_addr, pm_wdata);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_addwf;
    begin_load(12'h010);
    send(M_ADDWF, 7, 1, 0, 0);
    compared++;
    if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 9'h010, 12'h1E7}) begin
      mismatched++;
      $display("FAIL addwf we/addr/data got=%b/%h/%h required 1/010/1e7", pm_we, pm_addr, pm_wdata);
    end
    tick();
    compared++;
    if (pm_we !== 1'b0) begin
      mismatched++;
      $display("FAIL addwf_we_drop got=%b required 0", pm_we);
    end
    end_load();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL addwf_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    begin_load(12'h020);
    send(M_BSF, 3, 0, 5, 0);
    compared++;
    if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 9'h020, 12'h5A3}) begin
      mismatched++;
      $display("FAIL bsf got=%b/%h/%h required 1/020/5a3", pm_we, pm_addr, pm_wdata);
    end
    send(M_GOTO, 0, 0, 0, 9'h1FF);
    compared++;
    if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 9'h021, 12'hBFF}) begin
      mismatched++;
      $display("FAIL goto got=%b/%h/%h required 1/021/bff", pm_we, pm_addr, pm_wdata);
    end
    send(M_MOVLW, 0, 0, 0, 9'h055);
    compared++;
    if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 9'h022, 12'hC55}) begin
      mismatched++;
      $display("FAIL movlw got=%b/%h/%h required 1/022/c55", pm_we, pm_addr, pm_wdata);
    end
    end_load();
  endtask

  task automatic test_tris_err;
    begin_load(12'h030);
    send(M_TRIS, 4, 0, 0, 0);
    compared++;
    if ({err, pm_we} !== 2'b10) begin
      mismatched++;
      $display("FAIL tris4 err/we got=%b/%b required 1/0", err, pm_we);
    end
    tick();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL tris4_err_pulse got=%b required 0", err);
    end
    send(M_TRIS, 6, 0, 0, 0);
    compared++;
    if ({err, pm_we, pm_addr, pm_wdata} !== {1'b0, 1'b1, 9'h030, 12'h006}) begin
      mismatched++;
      $display("FAIL tris6 got=%b/%b/%h/%h required 0/1/030/006", err, pm_we, pm_addr, pm_wdata);
    end
    end_load();
  endtask

  task automatic test_backpressure;
    begin_load(12'h040);
    pm_ready = 0;
    send(M_MOVLW, 0, 0, 0, 9'h012);
    in_valid = 1;
    in_mnem = M_XORLW;
    in_k = 9'h034;
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if ({in_ready, pm_we, pm_addr, pm_wdata} !== {1'b0, 1'b1, 9'h040, 12'hC12}) begin
        mismatched++;
        $display("FAIL stall_%0d rdy/we/addr/data got=%b/%b/%h/%h required 0/1/040/c12",
                 i, in_ready, pm_we, pm_addr, pm_wdata);
      end
      tick();
    end
    pm_ready = 1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 0;
    compared++;
    if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 9'h041, 12'hF34}) begin
      mismatched++;
      $display("FAIL stall_next got=%b/%h/%h required 1/041/f34", pm_we, pm_addr, pm_wdata);
    end
    end_load();
  endtask

  task automatic test_full;
    begin_load(12'h1FE);
    send(M_IORLW, 0, 0, 0, 9'h001);
    compared++;
    if ({pm_addr, pm_wdata} !== {9'h1FE, 12'hD01}) begin
      mismatched++;
      $display("FAIL full_w0 got=%h/%h required 1fe/d01", pm_addr, pm_wdata);
    end
    send(M_ANDLW, 0, 0, 0, 9'h002);
    compared++;
    if ({pm_addr, pm_wdata} !== {9'h1FF, 12'hE02}) begin
      mismatched++;
      $display("FAIL full_w1 got=%h/%h required 1ff/e02", pm_addr, pm_wdata);
    end
    in_valid = 1;
    in_mnem = M_NOP;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_refuse_early in_ready=%b required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({full, in_ready, pm_we} !== 3'b100) begin
        mismatched++;
        $display("FAIL full_state_%0d full/rdy/we got=%b/%b/%b required 1/0/0", i, full, in_ready, pm_we);
      end
    end
    in_valid = 0;
    end_load();
    compared++;
    if ({busy, full} !== 2'b00) begin
      mismatched++;
      $display("FAIL full_finish busy/full got=%b/%b required 0/0", busy, full);
    end
  endtask

`ifdef INS_ENCODE_CHECKSUM_EN
  task automatic test_checksum;
    begin_load(12'h060);
    send(M_RETLW, 0, 0, 0, 0);
    send(M_CALL, 0, 0, 0, 0);
    end_load();
    compared++;
    if (checksum !== 12'h100) begin
      mismatched++;
      $display("FAIL checksum got=%h required 100", checksum);
    end
    begin_load(12'h070);
    compared++;
    if (checksum !== 12'h000) begin
      mismatched++;
      $display("FAIL checksum_clear got=%h required 000", checksum);
    end
    end_load();
  endtask
`endif

  task automatic test_reset_drain;
    begin_load(12'h050);
    pm_ready = 0;
    send(M_SLEEP, 0, 0, 0, 0);
    finish = 1;
    tick();
    finish = 0;
    compared++;
    if ({busy, pm_we, pm_wdata} !== {1'b1, 1'b1, 12'h003}) begin
      mismatched++;
      $display("FAIL drain_hold busy/we/data got=%b/%b/%h required 1/1/003", busy, pm_we, pm_wdata);
    end
    #2;
    reset = 1;
    #1;
    compared++;
    if ({pm_we, in_ready, busy, full, err, pm_addr, pm_wdata} !== '0) begin
      mismatched++;
      $display("FAIL drain_reset got=%b/%b/%b/%b/%b/%h/%h required all zero",
               pm_we, in_ready, busy, full, err, pm_addr, pm_wdata);
    end
`ifdef INS_ENCODE_CHECKSUM_EN
    compared++;
    if (checksum !== 12'h000) begin
      mismatched++;
      $display("FAIL drain_reset_checksum got=%h required 000", checksum);
    end
`endif
    tick();
    reset = 0;
    pm_ready = 1;
    tick();
  endtask

  task automatic test_random;
    int exp_q[$];
    int addr, sent, w, exp_w, exp_err, cycles;
    bit ill, acc;
    addr = 12'h080;
    sent = 0;
    exp_err = 0;
    cycles = 0;
    begin_load(addr);
    while (sent < 200 && cycles < 4000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        in_mnem = 6'($urandom_range(0, 40));
        in_f = 5'($urandom_range(0, 31));
        in_d = 1'($urandom_range(0, 1));
        in_bit = 3'($urandom_range(0, 7));
        in_k = 9'($urandom_range(0, 511));
      end
      pm_ready = ($urandom_range(0, 3) != 0);
      #1;
      compared++;
      if (err !== 1'(exp_err)) begin
        mismatched++;
        $display("FAIL rnd_err cycle=%0d got=%b required=%0d", cycles, err, exp_err);
      end
      if (pm_we && pm_ready) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        compared++;
        if (exp_w != int'({pm_addr, pm_wdata})) begin
          mismatched++;
          $display("FAIL rnd_write addr/data=%h/%h required=%h", pm_addr, pm_wdata, exp_w);
        end
      end
      exp_err = 0;
      acc = in_valid && in_ready;
      if (acc) begin
        model(int'(in_mnem), int'(in_f), int'(in_d), int'(in_bit), int'(in_k), w, ill);
        if (!ill) begin
          exp_q.push_back(addr * 4096 + w);
          addr++;
        end
        exp_err = ill;
        sent++;
      end
      tick();
      if (acc) in_valid = 0;
      cycles++;
    end
    pm_ready = 1;
    for (int n = 0; n < 3; n++) begin
      #1;
      compared++;
      if (err !== 1'(exp_err)) begin
        mismatched++;
        $display("FAIL rnd_tail_err got=%b required=%0d", err, exp_err);
      end
      exp_err = 0;
      if (pm_we) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        compared++;
        if (exp_w != int'({pm_addr, pm_wdata})) begin
          mismatched++;
          $display("FAIL rnd_tail_write addr/data=%h/%h required=%h", pm_addr, pm_wdata, exp_w);
        end
      end
      tick();
    end
    compared++;
    if (sent != 200 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_complete sent=%0d left=%0d required 200/0", sent, exp_q.size());
    end
    end_load();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addwf();
    test_back_to_back();
    test_tris_err();
    test_backpressure();
    test_full();
`ifdef INS_ENCODE_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
